// File: rtl/serial_mag_comparator.sv
// Word-level sequencer for the 1-bit comparator cell: accepts two operands,
// streams them LSB-first with the running cascade, and returns a registered verdict.
module serial_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  output logic             ser_valid,
  output logic             ser_x,
  output logic             ser_y,
  output logic             ser_a,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {C_EQ, C_GT, C_LT} casc_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  casc_t            casc_q, casc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             bit_x, bit_y;

  assign bit_x = x_q[cnt_q];
  assign bit_y = y_q[cnt_q];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    casc_d    = casc_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    res_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = op_x;
          y_d     = op_y;
          cnt_d   = '0;
          casc_d  = C_EQ;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        // A differing higher bit always overrides whatever the lower bits decided.
        if (bit_x && !bit_y)      casc_d = C_GT;
        else if (!bit_x && bit_y) casc_d = C_LT;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          gt_d    = (casc_d == C_GT);
          eq_d    = (casc_d == C_EQ);
          lt_d    = (casc_d == C_LT);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The serial bit lanes are forced low whenever no live bit pair is being presented.
  assign ser_x = ser_valid & bit_x;
  assign ser_y = ser_valid & bit_y;
  assign ser_a = ser_valid & (casc_q == C_GT);
  assign gt    = gt_q;
  assign eq    = eq_q;
  assign lt    = lt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      casc_q  <= C_EQ;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      casc_q  <= casc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator at WIDTH=4: serial stream, verdicts,
// backpressure and asynchronous reset aborts.
module tb_serial_mag_comparator;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_x = '0;
  logic [W-1:0] op_y = '0;
  logic         ser_valid, ser_x, ser_y, ser_a;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic         gt, eq, lt;

  int n_checks = 0;
  int n_fail   = 0;

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_x     (op_x),
    .op_y     (op_y),
    .ser_valid(ser_valid),
    .ser_x    (ser_x),
    .ser_y    (ser_y),
    .ser_a    (ser_a),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .gt       (gt),
    .eq       (eq),
    .lt       (lt)
  );

  always #5 clk = ~clk;

  // Bundle order: {in_ready, ser_valid, ser_x, ser_y, ser_a, res_valid, gt, eq, lt}
  localparam logic [8:0] RESET_VEC = 9'b1_0000_0000;

  // Presents one operand pair for a single edge; returns #1 after the accept edge.
  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    op_x     = x;
    op_y     = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_x     = '0;
    op_y     = '0;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    obs = {in_ready, ser_valid, ser_x, ser_y, ser_a, res_valid, gt, eq, lt};
    n_checks++;
    if (obs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, RESET_VEC);
    end
    accept(4'b1010, 4'b0110);
    @(posedge clk); #1;
    n_checks++;
    if (ser_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_async_shift: ser_valid=%b in_ready=%b expected 1 0", ser_valid, in_ready);
    end
    #1;
    rst = 1'b1;
    #1;
    obs = {in_ready, ser_valid, ser_x, ser_y, ser_a, res_valid, gt, eq, lt};
    n_checks++;
    if (obs !== RESET_VEC) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", obs, RESET_VEC);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: in_ready=%b res_valid=%b expected 1 0", in_ready, res_valid);
    end
  endtask

  // Full compare with res_ready high: checks each serial cycle, the verdict, and the return to IDLE.
  task automatic test_compare(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] exp_a, input logic [2:0] exp_v);
    logic [2:0] obs_v;
    res_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b expected 1", name, in_ready);
    end
    accept(x, y);
    for (int i = 0; i < W; i++) begin
      n_checks++;
      if ({ser_valid, ser_x, ser_y, ser_a, in_ready, res_valid} !== {1'b1, x[i], y[i], exp_a[i], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s bit%0d: got v=%b x=%b y=%b a=%b rdy=%b rv=%b expected v=1 x=%b y=%b a=%b rdy=0 rv=0",
                 name, i, ser_valid, ser_x, ser_y, ser_a, in_ready, res_valid, x[i], y[i], exp_a[i]);
      end
      @(posedge clk); #1;
    end
    obs_v = {gt, eq, lt};
    n_checks++;
    if (res_valid !== 1'b1 || ser_valid !== 1'b0 || in_ready !== 1'b0 || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s verdict: got rv=%b sv=%b rdy=%b gel=%b expected rv=1 sv=0 rdy=0 gel=%b",
               name, res_valid, ser_valid, in_ready, obs_v, exp_v);
    end
    @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got rv=%b rdy=%b expected rv=0 rdy=1", name, res_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] obs_v;
    res_ready = 1'b0;
    accept(4'b0011, 4'b1000);
    repeat (W) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op_x     = 4'b1111;
      op_y     = 4'b0000;
      obs_v    = {gt, eq, lt};
      n_checks++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || ser_valid !== 1'b0 || obs_v !== 3'b001) begin
        n_fail++;
        $display("FAIL hold_done%0d: got rv=%b rdy=%b sv=%b gel=%b expected rv=1 rdy=0 sv=0 gel=001",
                 i, res_valid, in_ready, ser_valid, obs_v);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    n_checks++;
    if (res_valid !== 1'b1 || {gt, eq, lt} !== 3'b001) begin
      n_fail++;
      $display("FAIL hold_final: got rv=%b gel=%b expected rv=1 gel=001", res_valid, {gt, eq, lt});
    end
    @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || ser_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_idle: got rv=%b rdy=%b sv=%b expected 0 1 0", res_valid, in_ready, ser_valid);
    end
    // 1100 vs 0101: LT after bit 0, GT decided by the MSB.
    test_compare("after_bp", 4'b1100, 4'b0101, 4'b0000, 3'b100);
  endtask

  task automatic test_reset_mid_shift();
    accept(4'b1010, 4'b0110);
    @(posedge clk); #1;
    n_checks++;
    if (ser_valid !== 1'b1 || ser_x !== 1'b1 || ser_y !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_second_shift: got sv=%b x=%b y=%b expected 1 1 1", ser_valid, ser_x, ser_y);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || ser_valid !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: got rdy=%b sv=%b rv=%b expected 1 0 0", in_ready, ser_valid, res_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      n_checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_no_verdict%0d: got rv=%b rdy=%b expected 0 1", i, res_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    // 5 vs 3: LT after bit 1, GT after bit 2, so ser_a is high only on the last bit.
    test_compare("x5_y3", 4'd5, 4'd3, 4'b1000, 3'b100);
  endtask

  initial begin
    test_reset();
    test_compare("x1010_y0110", 4'b1010, 4'b0110, 4'b0000, 3'b100);
    test_compare("x0011_y1000", 4'b0011, 4'b1000, 4'b1110, 3'b001);
    test_compare("eq_ones",     4'b1111, 4'b1111, 4'b0000, 3'b010);
    test_compare("eq_zeros",    4'b0000, 4'b0000, 4'b0000, 3'b010);
    test_backpressure();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
